// File: rtl/jump_pkg.sv
// Shared definitions for the jump game: squeeze width/limit, button FSM states
// and the saturating squeeze increment.
package jump_pkg;

    localparam int SQUEEZE_W           = 4;
    localparam int SQUEEZE_MAX_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        LOCKOUT = 2'd2
    } btn_state_t;

    // Increment a squeeze level, sticking at max_v instead of wrapping.
    function automatic logic [SQUEEZE_W-1:0] sat_inc(
        input logic [SQUEEZE_W-1:0] v,
        input logic [SQUEEZE_W-1:0] max_v
    );
        if (v >= max_v) begin
            sat_inc = max_v;
        end else begin
            sat_inc = v + 4'd1;
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer for the raw jump button.
// o_rise/o_fall are high on the cycle whose clock edge changes o_level, so a
// consumer registering them lines up with the new stable level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] db_cnt_q;
    logic [CNT_W-1:0] db_cnt_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= i_btn;
            s2_q <= s1_q;
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_comb begin
        db_cnt_d = db_cnt_q;
        level_d  = level_q;
        if (s2_q == level_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == CNT_LAST) begin
            level_d  = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + CNT_W'(1);
        end
    end

    // Debounce counter and stable level state.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = level_d & ~level_q;
    assign o_fall  = ~level_d & level_q;

endmodule

// File: rtl/btn_charge_conditioner.sv
// Jump button conditioner: debounces the button, accepts presses only while
// the game FSM is armed, grows a squeeze level while held and latches it as
// the charge on release. A press seen while unarmed is locked out until the
// button is let go.
module btn_charge_conditioner
    import jump_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int STEP_CYCLES     = 1048576,
    parameter int SQUEEZE_MAX     = SQUEEZE_MAX_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_btn,
    input  logic                 i_arm,
    output logic                 o_btn_level,
    output logic                 o_press,
    output logic                 o_release,
    output logic [SQUEEZE_W-1:0] o_squeeze,
    output logic [SQUEEZE_W-1:0] o_charge
);

    localparam int                   STEP_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [SQUEEZE_W-1:0] SQ_MAX    = SQUEEZE_W'(SQUEEZE_MAX);

    logic rise_s;
    logic fall_s;

    btn_state_t           state_q,   state_d;
    logic [STEP_W-1:0]    step_q,    step_d;
    logic [SQUEEZE_W-1:0] squeeze_q, squeeze_d;
    logic [SQUEEZE_W-1:0] charge_q,  charge_d;
    logic                 press_q,   press_d;
    logic                 release_q, release_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (i_btn),
        .o_level(o_btn_level),
        .o_rise (rise_s),
        .o_fall (fall_s)
    );

    // Press acceptance, squeeze stepping and charge capture; fall beats a step wrap.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        squeeze_d = squeeze_q;
        charge_d  = charge_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_s) begin
                    if (i_arm) begin
                        state_d   = CHARGE;
                        press_d   = 1'b1;
                        step_d    = '0;
                        squeeze_d = '0;
                    end else begin
                        state_d = LOCKOUT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CHARGE: begin
                if (fall_s) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    charge_d  = squeeze_q;
                    squeeze_d = '0;
                    step_d    = '0;
                end else if (step_q == STEP_LAST) begin
                    step_d    = '0;
                    squeeze_d = sat_inc(squeeze_q, SQ_MAX);
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            LOCKOUT: begin
                if (fall_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = LOCKOUT;
                end
            end
            default: begin
                state_d   = IDLE;
                step_d    = '0;
                squeeze_d = '0;
            end
        endcase
    end

    // FSM, counters and registered strobes; reset abandons any charge in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            squeeze_q <= '0;
            charge_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            squeeze_q <= squeeze_d;
            charge_q  <= charge_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_squeeze = squeeze_q;
    assign o_charge  = charge_q;

endmodule
